// File: rtl/pdm_rx_pkg.sv
// Shared sizing helpers and stage-mode type for the PDM receive CIC decimator.
package pdm_rx_pkg;

  typedef enum logic {
    STAGE_INTEG = 1'b0,
    STAGE_COMB  = 1'b1
  } stage_mode_e;

  function automatic int unsigned cic_w(input int unsigned order, input int unsigned log2r);
    return order * log2r + 1;
  endfunction

  // Combs need one tick per stage before their delay registers hold real history.
  function automatic int unsigned warmup_ticks(input int unsigned order);
    return order;
  endfunction

  function automatic bit params_legal(input int unsigned order, input int unsigned log2r,
                                      input int unsigned out_w);
    return (order >= 1) && (order <= 4) && (log2r >= 1) && (out_w >= 1) &&
           (out_w <= order * log2r);
  endfunction

endpackage

// File: rtl/pdm_rx_decimator_cic_stage.sv
// One CIC stage: integrator (output is the held sum) or comb (differential delay 1).
module cic_stage
  import pdm_rx_pkg::*;
#(
  parameter int unsigned W    = 19,
  parameter stage_mode_e MODE = STAGE_INTEG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (MODE == STAGE_INTEG) begin
      y = state_q;
      if (en) state_d = state_q + x;
    end else begin
      y = x - state_q;
      if (en) state_d = x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state_q <= '0;
    else                 state_q <= state_d;
  end

endmodule

// File: rtl/pdm_rx_decimator.sv
// PDM-to-PCM CIC decimator: ORDER pipelined integrators, ORDER combs at 1/R rate.
module pdm_rx_decimator
  import pdm_rx_pkg::*;
#(
  parameter int unsigned ORDER  = 3,
  parameter int unsigned LOG2_R = 6,
  parameter int unsigned OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_en,
  input  logic             pdm_in,
  input  logic             clear,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             settled
);

  localparam int unsigned W     = cic_w(ORDER, LOG2_R);
  localparam int unsigned SHIFT = W - 1 - OUT_W;
  localparam logic [2:0]  WARMUP_CNT = 3'(warmup_ticks(ORDER));
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};

  if (!params_legal(ORDER, LOG2_R, OUT_W)) begin : g_bad_params
    $error("pdm_rx_decimator: illegal ORDER/LOG2_R/OUT_W combination");
  end

  logic [LOG2_R-1:0] cnt_q, cnt_d;
  logic [2:0]        warm_q, warm_d;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              settled_q, settled_d;
  logic              tick;
  logic [W-1:0]      sat;

  logic [W-1:0] integ_y [ORDER+1];
  logic [W-1:0] comb_y  [ORDER+1];

  assign integ_y[0] = W'(pdm_in);
  // Comb input is the post-update value of the last integrator, formed here
  // since the stage only exposes its held sum.
  assign comb_y[0]  = integ_y[ORDER] + integ_y[ORDER-1];

  for (genvar k = 1; k <= ORDER; k++) begin : g_stages
    cic_stage #(.W(W), .MODE(STAGE_INTEG)) u_integ (
      .clk(clk), .rst_n(rst_n), .clear(clear), .en(pdm_en),
      .x(integ_y[k-1]), .y(integ_y[k])
    );
    cic_stage #(.W(W), .MODE(STAGE_COMB)) u_comb (
      .clk(clk), .rst_n(rst_n), .clear(clear), .en(tick),
      .x(comb_y[k-1]), .y(comb_y[k])
    );
  end

  assign tick = pdm_en && (cnt_q == '1);

  always_comb begin
    cnt_d     = cnt_q;
    warm_d    = warm_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    settled_d = settled_q;
    sat       = (comb_y[ORDER] > SAT_MAX) ? SAT_MAX : comb_y[ORDER];
    if (pdm_en) cnt_d = cnt_q + LOG2_R'(1);
    if (tick) begin
      sample_d = OUT_W'(sat >> SHIFT);
      if (warm_q == WARMUP_CNT) begin
        valid_d   = 1'b1;
        settled_d = 1'b1;
      end else begin
        warm_d = warm_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q     <= '0;
      warm_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      warm_q    <= warm_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      settled_q <= settled_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign settled      = settled_q;

endmodule

// File: tb/tb_pdm_rx_decimator.sv
// Self-checking bench for pdm_rx_decimator against an impulse-response reference model.
module tb_pdm_rx_decimator;

  localparam int ORDER  = 3;
  localparam int LOG2_R = 6;
  localparam int OUT_W  = 16;
  localparam int R      = 1 << LOG2_R;
  localparam int W      = ORDER * LOG2_R + 1;
  localparam int SHIFT  = W - 1 - OUT_W;
  localparam int HLEN   = (ORDER - 1) + ORDER * (R - 1) + 1;
  localparam longint SAT_MAX = (64'sd1 << (W - 1)) - 1;

  logic             clk;
  logic             rst_n;
  logic             pdm_en;
  logic             pdm_in;
  logic             clear;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             settled;

  pdm_rx_decimator #(.ORDER(ORDER), .LOG2_R(LOG2_R), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_en(pdm_en), .pdm_in(pdm_in), .clear(clear),
    .sample_out(sample_out), .sample_valid(sample_valid), .settled(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;
  longint h [HLEN];
  bit     hist [$];
  int     nticks;
  bit     exp_valid, exp_settled;
  longint exp_sample;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Impulse response: ORDER cascaded length-R boxcars, delayed ORDER-1 bits by the
  // pipelined integrator chain.
  task automatic build_h();
    longint tmp [HLEN];
    foreach (h[i]) h[i] = 0;
    h[ORDER-1] = 1;
    repeat (ORDER) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) tmp[i] += h[i-j];
      end
      h = tmp;
    end
  endtask

  function automatic longint model_sample();
    longint acc = 0;
    int n = hist.size();
    for (int k = 0; k < HLEN; k++)
      if (n - 1 - k >= 0 && hist[n-1-k]) acc += h[k];
    if (acc > SAT_MAX) acc = SAT_MAX;
    return acc >>> SHIFT;
  endfunction

  task automatic step(input bit en, input bit din, input bit clr, input bit rstn);
    pdm_en = en; pdm_in = din; clear = clr; rst_n = rstn;
    @(posedge clk);
    cycle++;
    exp_valid = 1'b0;
    if (!rstn || clr) begin
      hist.delete();
      nticks = 0; exp_settled = 1'b0; exp_sample = 0;
    end else if (en) begin
      hist.push_back(din);
      if (hist.size() % R == 0) begin
        nticks++;
        exp_sample = model_sample();
        if (nticks > ORDER) begin
          exp_valid = 1'b1; exp_settled = 1'b1;
        end
      end
    end
    #1;
    check("sample_valid", 64'(sample_valid), 64'(exp_valid));
    check("settled", 64'(settled), 64'(exp_settled));
    check("sample_out", 64'(sample_out), 64'(exp_sample));
  endtask

  typedef struct {
    string       name;
    int          pattern;   // 0 const 0, 1 const 1, 2 alternating 1,0,...
    int          period;    // pdm_en high every period-th cycle
    int          steps;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs [5];

  task automatic clear_test(input bit use_rst, input string tag);
    int  n;
    bit  found;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (R * 5 + 30) step(1'b1, 1'b1, 1'b0, 1'b1);
    check({tag, "_pre_settled"}, 64'(settled), 64'd1);
    check({tag, "_pre_sample"}, 64'(sample_out), 64'hFFFF);
    if (use_rst) step(1'b1, 1'b1, 1'b0, 1'b0);
    else         step(1'b1, 1'b1, 1'b1, 1'b1);
    check({tag, "_post_sample"}, 64'(sample_out), 64'd0);
    check({tag, "_post_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_post_settled"}, 64'(settled), 64'd0);
    n = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      n++;
      if (sample_valid) found = 1'b1;
    end
    check({tag, "_valid_found"}, 64'(found), 64'd1);
    check({tag, "_bits_to_valid"}, 64'(n), 64'(4 * R));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int first, last, bi, nvalid, dens;
    bit en, din, clr, rstn;
    logic [16:0] acc;

    build_h();
    rst_n = 1'b0; clear = 1'b0; pdm_en = 1'b0; pdm_in = 1'b0;
    nticks = 0; exp_settled = 1'b0; exp_valid = 1'b0; exp_sample = 0;

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_sample", 64'(sample_out), 64'd0);
    check("reset_valid", 64'(sample_valid), 64'd0);
    check("reset_settled", 64'(settled), 64'd0);

    vecs[0] = '{"const0",   0, 1, 1024, 16'h0000};
    vecs[1] = '{"const1",   1, 1, 1024, 16'hFFFF};
    vecs[2] = '{"alt",      2, 1, 1024, 16'h8000};
    vecs[3] = '{"sparse5",  1, 5, 2600, 16'hFFFF};
    vecs[4] = '{"altsp3",   2, 3, 1500, 16'h8000};

    foreach (vecs[v]) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      first = 0; last = 0; bi = 0;
      for (int s = 1; s <= vecs[v].steps; s++) begin
        en = (s % vecs[v].period) == 0;
        if (en) begin
          din = (vecs[v].pattern == 1) || (vecs[v].pattern == 2 && bi % 2 == 0);
          bi++;
        end else begin
          din = 1'($urandom);
        end
        step(en, din, 1'b0, 1'b1);
        if (sample_valid) begin
          check({vecs[v].name, "_value"}, 64'(sample_out), 64'(vecs[v].exp_val));
          if (first == 0) first = s;
          else check({vecs[v].name, "_spacing"}, 64'(s - last), 64'(R * vecs[v].period));
          last = s;
        end
      end
      check({vecs[v].name, "_first_valid"}, 64'(first), 64'(4 * R * vecs[v].period));
    end

    clear_test(1'b0, "clear30");
    clear_test(1'b1, "reset30");

    step(1'b1, 1'b1, 1'b1, 1'b1);
    dens = 50;
    for (int s = 0; s < 6000; s++) begin
      if (s % 500 == 0) dens = $urandom_range(0, 100);
      en   = $urandom_range(0, 3) != 0;
      din  = $urandom_range(0, 99) < dens;
      clr  = $urandom_range(0, 1999) == 0;
      rstn = $urandom_range(0, 2999) != 0;
      step(en, din, clr, rstn);
    end

    // Loopback: first-order sigma-delta coding of 0x1000 feeds the decimator.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    acc = '0; nvalid = 0;
    for (int s = 0; s < 8000 && nvalid < 100; s++) begin
      acc = {1'b0, acc[15:0]} + 17'h01000;
      step(1'b1, acc[16], 1'b0, 1'b1);
      if (sample_valid) begin
        nvalid++;
        check("loopback_within_2lsb",
              64'((int'(sample_out) >= 16'h1000 - 2) && (int'(sample_out) <= 16'h1000 + 2)), 64'd1);
      end
    end
    check("loopback_count", 64'(nvalid), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
